// File: rtl/brd_pkt_cmd_engine_if.sv
// Byte-stream link between the Ethernet PHY side and the command engine.
// Each stream word is {cke, frm, data[7:0]}.
interface brd_pkt_cmd_engine_if;
  logic [9:0] in_eth_stream;
  logic [9:0] out_eth_stream;

  // PHY side: sources request beats, sinks response beats
  modport master (
    output in_eth_stream,
    input  out_eth_stream
  );

  // Engine side
  modport slave (
    input  in_eth_stream,
    output out_eth_stream
  );
endinterface

// File: rtl/brd_pkt_cmd_engine.sv
// Command/response packet engine for the board Ethernet link.
// Parses framed request packets and executes register write, register read
// and status read commands against a bank of user control registers.
// It then streams an acknowledge or error response at a reduced byte rate.
module brd_pkt_cmd_engine #(
  parameter int N_REGS       = 8,
  parameter int REG_BYTES    = 2,
  parameter int STATUS_BYTES = 16,
  parameter int OUT_DIV      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  brd_pkt_cmd_engine_if.slave           eth,
  input  logic [8*STATUS_BYTES-1:0]     user_status,
  output logic [N_REGS*8*REG_BYTES-1:0] user_ctrl,
  output logic [N_REGS-1:0]             user_ctrl_strb,
  output logic                          busy,
  output logic [15:0]                   err_cnt
);

  localparam int REG_W     = 8 * REG_BYTES;
  localparam int ST_W      = 8 * STATUS_BYTES;
  localparam int PAY_BYTES = (STATUS_BYTES > REG_BYTES) ? STATUS_BYTES : REG_BYTES;
  // Longest response (3-byte error header or header + payload) fits here
  localparam int BUF_W     = 8 * (3 + PAY_BYTES);

  localparam logic [10:0] WR_LEN    = 11'(2 + REG_BYTES);
  localparam logic [10:0] RD_LEN    = 11'd2;
  localparam logic [10:0] ST_LEN    = 11'd1;
  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic [6:0]  RD_RESP   = 7'(2 + REG_BYTES);
  localparam logic [6:0]  ST_RESP   = 7'(1 + STATUS_BYTES);
  localparam logic [8:0]  N_REGS_W  = 9'(N_REGS);
  localparam logic [3:0]  DIV_LAST  = 4'(OUT_DIV - 1);

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_EXEC,
    S_TX
  } state_t;

  state_t state_q, state_next;

  logic       in_cke, in_frm;
  logic [7:0] in_data;

  logic              frm_prev_q;
  logic              drop_q;
  logic [7:0]        opcode_q;
  logic [7:0]        addr_q;
  logic [REG_W-1:0]  data_sr_q;
  logic [10:0]       rx_cnt_q;
  logic [REG_W-1:0]  regs_q [N_REGS];
  logic [N_REGS-1:0] strb_q;
  logic [15:0]       err_q;
  logic [BUF_W-1:0]  tx_buf_q;
  logic [6:0]        rem_q;
  logic [3:0]        ph_q;
  logic              trailer_q;
  logic [9:0]        out_q;

  logic              frame_start;
  logic              accept;
  logic              drop_evt;
  logic              err_evt;
  logic              wr_commit;
  logic              tx_slot;
  logic              op_known;
  logic [10:0]       exp_len;
  logic [7:0]        err_code;
  logic [REG_W-1:0]  rd_data;
  logic [BUF_W-1:0]  resp_buf;
  logic [6:0]        resp_len;
  logic [REG_W+7:0]  shift_in;
  logic [1:0]        err_inc;
  logic [16:0]       err_sum;

  assign in_cke  = eth.in_eth_stream[9];
  assign in_frm  = eth.in_eth_stream[8];
  assign in_data = eth.in_eth_stream[7:0];

  // A frame start is the first frm beat after a beat that closed a frame
  assign frame_start = in_cke & in_frm & ~frm_prev_q;
  // The next cycle is a tick when the current output phase is the last one
  assign tx_slot     = (ph_q == DIV_LAST);
  assign shift_in    = {data_sr_q, in_data};

  // Next-state logic and per-cycle event decode
  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    drop_evt   = 1'b0;
    err_evt    = 1'b0;
    wr_commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start && !drop_q) begin
          accept     = 1'b1;
          state_next = S_RX;
        end
      end
      S_RX: begin
        if (in_cke && !in_frm) state_next = S_EXEC;
      end
      S_EXEC: begin
        drop_evt   = frame_start & ~drop_q;
        err_evt    = (err_code != 8'h00);
        wr_commit  = (err_code == 8'h00) && (opcode_q == OP_WRITE);
        state_next = S_TX;
      end
      S_TX: begin
        drop_evt = frame_start & ~drop_q;
        if (tx_slot && trailer_q) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command validation: unknown opcode, then length, then address range
  always_comb begin
    op_known = 1'b1;
    exp_len  = ST_LEN;
    err_code = 8'h00;
    case (opcode_q)
      OP_WRITE:  exp_len = WR_LEN;
      OP_READ:   exp_len = RD_LEN;
      OP_STATUS: exp_len = ST_LEN;
      default:   op_known = 1'b0;
    endcase
    if (!op_known)
      err_code = 8'h01;
    else if (rx_cnt_q != exp_len)
      err_code = 8'h02;
    else if (opcode_q != OP_STATUS && {1'b0, addr_q} >= N_REGS_W)
      err_code = 8'h03;
  end

  // Register read mux for the READ response
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (addr_q == 8'(k)) rd_data = regs_q[k];
    end
  end

  // Assemble the whole response MSB-aligned so TX just shifts bytes out
  always_comb begin
    resp_buf = '0;
    resp_len = 7'd3;
    if (err_code != 8'h00) begin
      resp_buf[BUF_W-1 -: 24] = {8'hFF, err_code, opcode_q};
      resp_len = 7'd3;
    end else begin
      case (opcode_q)
        OP_WRITE: begin
          resp_buf[BUF_W-1 -: 16] = {8'h81, addr_q};
          resp_len = 7'd2;
        end
        OP_READ: begin
          resp_buf[BUF_W-1 -: 16]     = {8'h82, addr_q};
          resp_buf[BUF_W-17 -: REG_W] = rd_data;
          resp_len = RD_RESP;
        end
        default: begin
          resp_buf[BUF_W-1 -: 8]     = 8'h83;
          resp_buf[BUF_W-9 -: ST_W]  = user_status;
          resp_len = ST_RESP;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_next;
  end

  // Line framing tracker, deliberately kept across reset so a frame still arriving after reset is skipped
  always_ff @(posedge clk) begin
    if (in_cke) frm_prev_q <= in_frm;
  end

  // Drop flag: set by a frame starting while busy, cleared by that frame's end beat
  always_ff @(posedge clk) begin
    if (rst)                     drop_q <= 1'b0;
    else if (drop_evt)           drop_q <= 1'b1;
    else if (in_cke && !in_frm)  drop_q <= 1'b0;
  end

  // Request capture: opcode, address, data bytes shifted MSB first, saturating length
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      addr_q    <= '0;
      data_sr_q <= '0;
      rx_cnt_q  <= '0;
    end else if (accept) begin
      opcode_q  <= in_data;
      addr_q    <= '0;
      data_sr_q <= '0;
      rx_cnt_q  <= 11'd1;
    end else if (state_q == S_RX && in_cke && in_frm) begin
      if (rx_cnt_q == 11'd1) addr_q <= in_data;
      else                   data_sr_q <= shift_in[REG_W-1:0];
      if (rx_cnt_q != CNT_MAX) rx_cnt_q <= rx_cnt_q + 11'd1;
    end
  end

  // Register bank and one-cycle write strobe, committed only from EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
      strb_q <= '0;
    end else begin
      strb_q <= '0;
      if (wr_commit) begin
        for (int k = 0; k < N_REGS; k++) begin
          if (addr_q == 8'(k)) begin
            regs_q[k] <= data_sr_q;
            strb_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign err_inc = {1'b0, err_evt} + {1'b0, drop_evt};
  assign err_sum = {1'b0, err_q} + {15'b0, err_inc};

  // Saturating error counter; a drop and a rejection can land in the same cycle
  always_ff @(posedge clk) begin
    if (rst)             err_q <= '0;
    else if (err_sum[16]) err_q <= 16'hFFFF;
    else                 err_q <= err_sum[15:0];
  end

  // Response transmitter: first byte loads as EXEC ends, then one byte per OUT_DIV cycles and a trailer slot
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      tx_buf_q  <= '0;
      rem_q     <= '0;
      ph_q      <= '0;
      trailer_q <= 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          out_q     <= {2'b11, resp_buf[BUF_W-1 -: 8]};
          tx_buf_q  <= resp_buf << 8;
          rem_q     <= resp_len - 7'd1;
          ph_q      <= '0;
          trailer_q <= 1'b0;
        end
        S_TX: begin
          ph_q <= tx_slot ? 4'd0 : ph_q + 4'd1;
          if (!tx_slot || trailer_q) begin
            out_q <= '0;
          end else if (rem_q != 7'd0) begin
            out_q    <= {2'b11, tx_buf_q[BUF_W-1 -: 8]};
            tx_buf_q <= tx_buf_q << 8;
            rem_q    <= rem_q - 7'd1;
          end else begin
            out_q     <= 10'h200;
            trailer_q <= 1'b1;
          end
        end
        default: out_q <= '0;
      endcase
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_flat
    assign user_ctrl[k*REG_W +: REG_W] = regs_q[k];
  end

  assign eth.out_eth_stream = out_q;
  assign user_ctrl_strb     = strb_q;
  assign busy               = (state_q != S_IDLE);
  assign err_cnt            = err_q;

endmodule

// File: tb/tb_brd_pkt_cmd_engine.sv
// Directed testbench for brd_pkt_cmd_engine: write/read/status commands,
// error responses, frame dropping while busy, and reset during TX.
module tb_brd_pkt_cmd_engine;

  localparam int N_REGS       = 8;
  localparam int REG_BYTES    = 2;
  localparam int STATUS_BYTES = 16;
  localparam int OUT_DIV      = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] user_status;
  logic [127:0] user_ctrl;
  logic [7:0]   user_ctrl_strb;
  logic         busy;
  logic [15:0]  err_cnt;

  brd_pkt_cmd_engine_if eth ();

  brd_pkt_cmd_engine #(
    .N_REGS(N_REGS),
    .REG_BYTES(REG_BYTES),
    .STATUS_BYTES(STATUS_BYTES),
    .OUT_DIV(OUT_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eth(eth),
    .user_status(user_status),
    .user_ctrl(user_ctrl),
    .user_ctrl_strb(user_ctrl_strb),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int         vec_cnt = 0;
  int         miss_cnt = 0;
  int         cyc = 0;
  int         junk_cnt = 0;
  int         edges;
  logic       strb_seen = 1'b0;
  logic [9:0] resp_q [$];
  int         tick_cyc_q [$];
  logic [9:0] exp_q [$];
  logic [127:0] stat_a = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  logic [127:0] stat_b = 128'hDEAD_BEEF_0102_0304_0506_0708_090A_0B0C;
  logic [127:0] ctrl_r3 = 128'h0000_0000_0000_0000_ABCD_0000_0000_0000;

  // Collect every response beat and flag any non-zero non-cke output word
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (eth.out_eth_stream[9] === 1'b1) begin
      resp_q.push_back(eth.out_eth_stream);
      tick_cyc_q.push_back(cyc);
    end else if (eth.out_eth_stream !== 10'h000 && rst === 1'b0) begin
      junk_cnt++;
    end
    if (user_ctrl_strb !== 8'h00 && rst === 1'b0) strb_seen = 1'b1;
  end

  task checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task applyStimulus(input logic [9:0] beat);
    eth.in_eth_stream = beat;
    @(posedge clk);
    #1;
  endtask

  task sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                 input logic [7:0] b3, input int n);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < n; i++) applyStimulus({2'b11, b[i]});
    applyStimulus(10'h25A);
    eth.in_eth_stream = 10'h000;
  endtask

  task waitIdle(input string tag, output int n_edges);
    n_edges = 0;
    while (busy && n_edges < 3000) begin
      @(posedge clk);
      #1;
      n_edges++;
    end
    checkOutput(tag, {127'b0, busy}, 128'd0);
  endtask

  task checkResp(input string tag);
    checkOutput({tag, "_len"}, resp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
      checkOutput($sformatf("%s_b%0d", tag, i), resp_q[i], exp_q[i]);
  endtask

  task clearCapture;
    resp_q.delete();
    tick_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    eth.in_eth_stream = 10'h200;
    user_status = stat_a;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out", eth.out_eth_stream, 128'd0);
    checkOutput("rst_ctrl", user_ctrl, 128'd0);
    checkOutput("rst_strb", user_ctrl_strb, 128'd0);
    checkOutput("rst_busy", busy, 128'd0);
    checkOutput("rst_err", err_cnt, 128'd0);
    rst = 1'b0;
    eth.in_eth_stream = 10'h000;
    repeat (2) @(posedge clk);
    #1;

    // WRITE 01 03 AB CD: commit and first byte two cycles after the end beat
    clearCapture();
    sendFrame(8'h01, 8'h03, 8'hAB, 8'hCD, 4);
    checkOutput("wr_exec_ctrl", user_ctrl, 128'd0);
    checkOutput("wr_exec_busy", busy, 128'd1);
    @(posedge clk); #1;
    checkOutput("wr_strb", user_ctrl_strb, 128'h08);
    checkOutput("wr_ctrl", user_ctrl, ctrl_r3);
    checkOutput("wr_first", eth.out_eth_stream, 128'h381);
    @(posedge clk); #1;
    checkOutput("wr_strb_off", user_ctrl_strb, 128'd0);
    waitIdle("wr_idle", edges);
    // TX = 3 slots * 4 cycles from t+2; busy low at t+14, sampled here from t+3
    checkOutput("wr_tx_len", edges, 128'd11);
    exp_q = '{10'h381, 10'h303, 10'h200};
    checkResp("wr_resp");

    // READ 02 03: bytes spaced OUT_DIV apart
    clearCapture();
    sendFrame(8'h02, 8'h03, 8'h00, 8'h00, 2);
    waitIdle("rd_idle", edges);
    // EXEC + 5 slots * 4 cycles; busy low 21 edges after the EXEC cycle
    checkOutput("rd_tx_len", edges, 128'd21);
    exp_q = '{10'h382, 10'h303, 10'h3AB, 10'h3CD, 10'h200};
    checkResp("rd_resp");
    for (int i = 1; i < tick_cyc_q.size(); i++)
      checkOutput($sformatf("rd_gap%0d", i), tick_cyc_q[i] - tick_cyc_q[i-1], OUT_DIV);

    // STATUS: input changes after EXEC, response carries the earlier value
    clearCapture();
    sendFrame(8'h03, 8'h00, 8'h00, 8'h00, 1);
    @(posedge clk); #1;
    user_status = stat_b;
    waitIdle("st_idle", edges);
    exp_q = '{10'h383};
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b11, stat_a[127-8*i -: 8]});
    exp_q.push_back(10'h200);
    checkResp("st_resp");

    // Error responses
    strb_seen = 1'b0;
    clearCapture();
    sendFrame(8'h01, 8'h09, 8'h00, 8'h00, 4);
    waitIdle("e_addr_idle", edges);
    exp_q = '{10'h3FF, 10'h303, 10'h301, 10'h200};
    checkResp("e_addr");
    checkOutput("e_addr_strb", strb_seen, 128'd0);
    checkOutput("e_addr_ctrl", user_ctrl, ctrl_r3);

    clearCapture();
    sendFrame(8'h02, 8'h00, 8'h00, 8'h00, 1);
    waitIdle("e_len_idle", edges);
    exp_q = '{10'h3FF, 10'h302, 10'h302, 10'h200};
    checkResp("e_len");

    clearCapture();
    sendFrame(8'h7E, 8'h00, 8'h00, 8'h00, 1);
    waitIdle("e_op_idle", edges);
    exp_q = '{10'h3FF, 10'h301, 10'h37E, 10'h200};
    checkResp("e_op");
    checkOutput("err_cnt3", err_cnt, 128'd3);

    // Back-to-back: frame started during TX is dropped
    clearCapture();
    sendFrame(8'h02, 8'h03, 8'h00, 8'h00, 2);
    repeat (3) begin @(posedge clk); #1; end
    sendFrame(8'h01, 8'h05, 8'h11, 8'h22, 4);
    waitIdle("b2b_idle", edges);
    checkOutput("b2b_err", err_cnt, 128'd4);
    checkOutput("b2b_ctrl", user_ctrl, ctrl_r3);
    exp_q = '{10'h382, 10'h303, 10'h3AB, 10'h3CD, 10'h200};
    checkResp("b2b_resp");
    // Third frame starts in the very cycle busy falls
    clearCapture();
    sendFrame(8'h02, 8'h03, 8'h00, 8'h00, 2);
    waitIdle("b2b3_idle", edges);
    checkResp("b2b3_resp");

    // Reset pulsed mid-TX of a status response
    user_status = stat_a;
    clearCapture();
    sendFrame(8'h03, 8'h00, 8'h00, 8'h00, 1);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst2_out", eth.out_eth_stream, 128'd0);
    checkOutput("rst2_ctrl", user_ctrl, 128'd0);
    checkOutput("rst2_busy", busy, 128'd0);
    checkOutput("rst2_err", err_cnt, 128'd0);
    clearCapture();
    repeat (30) begin @(posedge clk); #1; end
    checkOutput("rst2_quiet", resp_q.size(), 128'd0);

    clearCapture();
    sendFrame(8'h01, 8'h02, 8'h12, 8'h34, 4);
    waitIdle("post_wr_idle", edges);
    exp_q = '{10'h381, 10'h302, 10'h200};
    checkResp("post_wr");
    clearCapture();
    sendFrame(8'h02, 8'h02, 8'h00, 8'h00, 2);
    waitIdle("post_rd_idle", edges);
    exp_q = '{10'h382, 10'h302, 10'h312, 10'h334, 10'h200};
    checkResp("post_rd");

    checkOutput("junk_words", junk_cnt, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
